// File: rtl/jpeg_quantizer.sv
// jpeg_quantizer: streaming 3-stage reciprocal-multiply quantizer with runtime luma/chroma tables
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_bank coefficient input
// (in_bank sampled on index 0 only); out_valid/out_ready/out_data/out_index/out_last quantized
// output; tbl_wr_en/tbl_wr_bank/tbl_wr_addr/tbl_wr_data table write port; sat_flag sticky
// saturation indicator. Optional macro QUANT_SAT_EN selects clamping instead of wrapping.
module jpeg_quantizer #(
  parameter int IN_W = 11,
  parameter int OUT_W = 11,
  parameter int RECIP_W = 16,
  parameter int FRAC_BITS = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_W-1:0]    in_data,
  input  logic                      in_bank,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic [5:0]                out_index,
  output logic                      out_last,
  input  logic                      tbl_wr_en,
  input  logic                      tbl_wr_bank,
  input  logic [5:0]                tbl_wr_addr,
  input  logic [RECIP_W-1:0]        tbl_wr_data,
  output logic                      sat_flag
);
  localparam int PW = IN_W + RECIP_W + 1;
  localparam int YW = PW + 1 - FRAC_BITS;
  localparam logic [PW:0] HALF = (PW+1)'(1 << (FRAC_BITS - 1));
  localparam logic [7:0] LQ [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99};
  localparam logic [7:0] CQ [64] = '{
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99};
  logic [RECIP_W-1:0] tbl [2][64];
  logic [5:0] cnt, i1, i2;
  logic blk_bank, bank, adv, acc, v1, v2, v3, ovf;
  logic signed [IN_W-1:0] c1;
  logic [RECIP_W-1:0] r1;
  logic signed [PW-1:0] p2;
  logic signed [PW:0] ps;
  logic signed [YW-1:0] y;
  logic [OUT_W-1:0] yq;
  logic unused;
  assign adv = !v3 || out_ready;
  assign in_ready = adv;
  assign acc = in_valid && adv;
  assign out_valid = v3;
  // index 0 takes the bank straight from the port; the rest of the block uses the latched copy
  assign bank = cnt == 6'd0 ? in_bank : blk_bank;
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < 64; i++) begin
        tbl[0][i] <= RECIP_W'((1 << FRAC_BITS) / int'(LQ[i]));
        tbl[1][i] <= RECIP_W'((1 << FRAC_BITS) / int'(CQ[i]));
      end
    else if (tbl_wr_en)
      tbl[tbl_wr_bank][tbl_wr_addr] <= tbl_wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      {v1, v2, v3} <= 3'b000;
      cnt <= 6'd0;
      blk_bank <= 1'b0;
      out_data <= '0;
      out_index <= 6'd0;
      out_last <= 1'b0;
    end else if (adv) begin
      {v1, v2, v3} <= {acc, v1, v2};
      if (acc) cnt <= cnt + 6'd1;
      if (acc && cnt == 6'd0) blk_bank <= in_bank;
      c1 <= in_data;
      i1 <= cnt;
      r1 <= tbl[bank][cnt];
      p2 <= PW'(c1) * PW'($signed({1'b0, r1}));
      i2 <= i1;
      if (v2) begin
        out_data <= yq;
        out_index <= i2;
        out_last <= i2 == 6'd63;
      end
    end
  // adding half an LSB before the arithmetic shift rounds half toward +inf
  always_comb begin
    ps = $signed({p2[PW-1], p2} + HALF);
    y = ps[PW:FRAC_BITS];
  end
`ifdef QUANT_SAT_EN
  localparam logic signed [YW-1:0] YMAX = YW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [YW-1:0] YMIN = ~YMAX;
  always_comb begin
    ovf = y > YMAX || y < YMIN;
    yq = y > YMAX ? YMAX[OUT_W-1:0] : y < YMIN ? YMIN[OUT_W-1:0] : y[OUT_W-1:0];
    unused = ^ps[FRAC_BITS-1:0];
  end
  always_ff @(posedge clk)
    if (rst) sat_flag <= 1'b0;
    else if (adv && v2 && ovf) sat_flag <= 1'b1;
`else
  always_comb begin
    ovf = 1'b0;
    yq = y[OUT_W-1:0];
    unused = ^{ps[FRAC_BITS-1:0], y[YW-1:OUT_W], ovf};
  end
  assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_jpeg_quantizer.sv
// tb_jpeg_quantizer: directed self-checking bench for jpeg_quantizer
module tb_jpeg_quantizer;
`ifdef QUANT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_bank = 1'b0;
  logic signed [10:0] in_data = '0;
  logic out_valid, out_ready = 1'b1, out_last, sat_flag;
  logic signed [10:0] out_data;
  logic [5:0] out_index;
  logic tbl_wr_en = 1'b0, tbl_wr_bank = 1'b0;
  logic [5:0] tbl_wr_addr = '0;
  logic [15:0] tbl_wr_data = '0;
  jpeg_quantizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bank(in_bank), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .tbl_wr_en(tbl_wr_en), .tbl_wr_bank(tbl_wr_bank),
    .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .sat_flag(sat_flag));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, nout = 0;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  int lq[64] = '{16, 11, 10, 16, 24, 40, 51, 61, 12, 12, 14, 19, 26, 58, 60, 55,
                 14, 13, 16, 24, 40, 57, 69, 56, 14, 17, 22, 29, 51, 87, 80, 62,
                 18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
                 49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
  int cq[64];
  int mtbl[2][64];
  int midx, mbank;
  typedef struct { int data; int index; } exp_t;
  exp_t q[$];
  function automatic int quant(input int c, input int r);
    longint y;
    int w;
    y = (longint'(c) * r + 2048) >>> 12;
    if (SAT) return y > 1023 ? 1023 : y < -1024 ? -1024 : int'(y);
    w = int'(y) & 2047;
    return w >= 1024 ? w - 2048 : w;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      cq[i] = (i < 4 || i == 8 || i == 9 || i == 10 || i == 11 || i == 16 || i == 17 || i == 18 ||
               i == 24 || i == 25) ? 0 : 99;
      mtbl[0][i] = 4096 / lq[i];
    end
    cq[0] = 17; cq[1] = 18; cq[2] = 24; cq[3] = 47; cq[8] = 18; cq[9] = 21; cq[10] = 26;
    cq[11] = 66; cq[16] = 24; cq[17] = 26; cq[18] = 56; cq[24] = 47; cq[25] = 66;
    for (int i = 0; i < 64; i++) mtbl[1][i] = 4096 / cq[i];
    midx = 0;
    mbank = 0;
    q.delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tbl_wr_en = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic push(input int c, input int b);
    exp_t e;
    if (midx == 0) mbank = b;
    e.data = quant(c, mtbl[mbank][midx]);
    e.index = midx;
    q.push_back(e);
    midx = (midx + 1) % 64;
  endtask
  task automatic send(input int c, input int b);
    int n = 0;
    in_valid = 1'b1;
    in_data = c[10:0];
    in_bank = b[0];
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else push(c, b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic one(input string tag, input int c, input int b, input int expv);
    send(c, b);
    check({tag, "_lat1"}, out_valid, 0);
    @(posedge clk);
    #1 check({tag, "_lat2"}, out_valid, 0);
    @(posedge clk);
    #1 check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, expv);
    check({tag, "_index"}, out_index, 0);
  endtask
  task automatic write_tbl(input int b, input int a, input int d);
    tbl_wr_en = 1'b1;
    tbl_wr_bank = b[0];
    tbl_wr_addr = a[5:0];
    tbl_wr_data = d[15:0];
    @(posedge clk);
    #1 tbl_wr_en = 1'b0;
    mtbl[b][a] = d;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1 check("drain", q.size(), 0);
  endtask
  bit stalled = 1'b0;
  logic signed [10:0] held_d;
  logic [5:0] held_i;
  always @(negedge clk) begin
    exp_t e;
    if (rst) stalled = 1'b0;
    else begin
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_d);
        check("stall_index", out_index, held_i);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_index", out_index, e.index);
          check("out_last", out_last, e.index == 63);
          nout++;
        end
      end
      stalled = out_valid && !out_ready;
      held_d = out_data;
      held_i = out_index;
    end
  end
  initial begin
    int k, n, base;
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat", sat_flag, 0);
    one("luma100", 100, 0, 6);
    do_reset();
    one("chroma1000", 1000, 1, 59);
    for (int i = 1; i < 64; i++) send((i * 97) % 2000 - 1000, 0);
    drain();
    do_reset();
    one("neg8", -8, 0, 0);
    do_reset();
    one("neg9", -9, 0, -1);
    do_reset();
    write_tbl(0, 0, 65535);
    one("sat", 1023, 0, SAT ? 1023 : -16);
    check("sat_flag", sat_flag, SAT ? 1 : 0);
    do_reset();
    base = nout;
    k = 0;
    n = 0;
    while (k < 128 && n < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      in_data = 11'(((k * 73) % 2047) - 1023);
      in_bank = k >= 64;
      @(negedge clk);
      if (in_ready) begin
        push(((k * 73) % 2047) - 1023, k >= 64 ? 1 : 0);
        k++;
      end
      @(posedge clk);
      #1 n++;
    end
    in_valid = 1'b0;
    check("stream_sent", k, 128);
    drain();
    check("stream_count", nout - base, 128);
    do_reset();
    write_tbl(0, 0, 65535);
    for (int i = 0; i < 20; i++) send(i * 5, 0);
    rst = 1'b1;
    check("pre_rst_valid", out_valid, 1);
    model_reset();
    @(posedge clk);
    #1 check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    rst = 1'b0;
    one("restored", 1000, 0, 63);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
